wave_sweep_ctrl: RTL



---
 rtl/wave_sweep_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/wave_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// wave_sweep_ctrl
// Sequencer for the ROM-based DDS tone generator.
//  - Divides CLK down to the sample rate and issues a one-cycle LATCH strobe
//    every CLK_DIV cycles (free-running, also in IDLE).
//  - Walks the 8-bit FREQ phase increment from START to STOP in STEP-sized
//    steps, holding each value for DWELL LATCH pulses (0 treated as 1).
//  - FREQ only changes on an edge where LATCH is high, so the tone generator
//    never sees a mid-sample change.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous active-high reset
//   CFG_VALID  host offers a sweep configuration
//   CFG_READY  high only in IDLE; handshake = CFG_VALID && CFG_READY
//   CFG_START  first FREQ value
//   CFG_STOP   final FREQ value
//   CFG_STEP   FREQ step magnitude (0 = hold START forever)
//   CFG_DWELL  LATCH pulses per FREQ value (0 behaves as 1)
//   ABORT      ends the active sweep at the next LATCH-high edge, no DONE
//   LATCH      one-cycle sample strobe
//   FREQ       phase increment to the tone generator
//   BUSY       high whenever not IDLE
//   DONE       one-cycle pulse on normal sweep completion
//
// Build option: define SWEEP_LOOP_EN to restart the sweep from START after
// every completed pass (DONE pulses once per pass; only ABORT/RST end it).
// ---------------------------------------------------------------------------
module wave_sweep_ctrl #(
    parameter int CLK_DIV = 1042,
    parameter int DWELL_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               CFG_VALID,
    output logic               CFG_READY,
    input  logic [7:0]         CFG_START,
    input  logic [7:0]         CFG_STOP,
    input  logic [7:0]         CFG_STEP,
    input  logic [DWELL_W-1:0] CFG_DWELL,
    input  logic               ABORT,
    output logic               LATCH,
    output logic [7:0]         FREQ,
    output logic               BUSY,
    output logic               DONE
);

    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2,
        LAST = 2'd3
    } state_t;

    // Unsigned 9-bit distance from the current value to the target in the
    // sweep direction; the sweep never overshoots, so this is never negative.
    function automatic logic [8:0] sweep_dist(input logic up, input logic [7:0] cur,
                                              input logic [7:0] tgt);
        logic [8:0] d;
        if (up) begin
            d = {1'b0, tgt} - {1'b0, cur};
        end else begin
            d = {1'b0, cur} - {1'b0, tgt};
        end
        return d;
    endfunction

    state_t             state_r, state_nxt;
    logic [CNT_W-1:0]   cnt_r;
    logic               latch_r;
    logic [7:0]         freq_r, freq_nxt;
    logic               done_r, done_nxt;
    logic               busy_r;
    logic               ready_r;
    logic [7:0]         start_r, stop_r, step_r;
    logic [DWELL_W-1:0] dwell_r;
    logic               up_r;
    logic [DWELL_W-1:0] dwell_cnt_r, dwell_cnt_nxt;
    logic               abort_r, abort_nxt;
    logic               cfg_take_s;
    logic               abort_pend_s;
    logic [DWELL_W-1:0] dwell_last_s;
    logic [8:0]         dist_s;

    assign LATCH     = latch_r;
    assign FREQ      = freq_r;
    assign BUSY      = busy_r;
    assign DONE      = done_r;
    assign CFG_READY = ready_r;

    // Abort request may arrive on the very LATCH edge, so include the live input.
    assign abort_pend_s = abort_r | ABORT;
    assign dwell_last_s = (dwell_r == {DWELL_W{1'b0}}) ? {DWELL_W{1'b0}}
                                                      : dwell_r - DWELL_W'(1);
    assign dist_s       = sweep_dist(up_r, freq_r, stop_r);

    // Sample-rate divider and registered LATCH strobe; runs in every state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r   <= {CNT_W{1'b0}};
            latch_r <= 1'b0;
        end else begin
            cnt_r   <= (cnt_r == CNT_MAX) ? {CNT_W{1'b0}} : cnt_r + CNT_W'(1);
            latch_r <= (cnt_r == CNT_MAX);
        end
    end

    // State register plus the registered datapath and status outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r     <= IDLE;
            freq_r      <= 8'd0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            ready_r     <= 1'b1;
            dwell_cnt_r <= {DWELL_W{1'b0}};
            abort_r     <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            freq_r      <= freq_nxt;
            done_r      <= done_nxt;
            busy_r      <= (state_nxt != IDLE);
            ready_r     <= (state_nxt == IDLE);
            dwell_cnt_r <= dwell_cnt_nxt;
            abort_r     <= abort_nxt;
        end
    end

    // Sweep configuration captured on the host handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            start_r <= 8'd0;
            stop_r  <= 8'd0;
            step_r  <= 8'd0;
            dwell_r <= {DWELL_W{1'b0}};
            up_r    <= 1'b0;
        end else if (cfg_take_s) begin
            start_r <= CFG_START;
            stop_r  <= CFG_STOP;
            step_r  <= CFG_STEP;
            dwell_r <= CFG_DWELL;
            up_r    <= (CFG_START <= CFG_STOP);
        end else begin
            start_r <= start_r;
            stop_r  <= stop_r;
            step_r  <= step_r;
            dwell_r <= dwell_r;
            up_r    <= up_r;
        end
    end

    // Next-state and datapath decisions; all sweep progress happens on LATCH edges.
    always_comb begin
        state_nxt     = state_r;
        freq_nxt      = freq_r;
        dwell_cnt_nxt = dwell_cnt_r;
        done_nxt      = 1'b0;
        abort_nxt     = abort_r;
        cfg_take_s    = 1'b0;

        case (state_r)
            IDLE: begin
                // ABORT has no meaning here; a simultaneous config still wins.
                abort_nxt = 1'b0;
                if (CFG_VALID) begin
                    cfg_take_s = 1'b1;
                    state_nxt  = ARM;
                end else begin
                    state_nxt  = IDLE;
                end
            end

            ARM: begin
                if (!latch_r) begin
                    abort_nxt = abort_pend_s;
                end else if (abort_pend_s) begin
                    freq_nxt      = 8'd0;
                    dwell_cnt_nxt = {DWELL_W{1'b0}};
                    abort_nxt     = 1'b0;
                    state_nxt     = IDLE;
                end else begin
                    freq_nxt      = start_r;
                    dwell_cnt_nxt = {DWELL_W{1'b0}};
                    state_nxt     = (start_r == stop_r) ? LAST : RUN;
                end
            end

            RUN, LAST: begin
                if (!latch_r) begin
                    abort_nxt = abort_pend_s;
                end else if (abort_pend_s) begin
                    freq_nxt      = 8'd0;
                    dwell_cnt_nxt = {DWELL_W{1'b0}};
                    abort_nxt     = 1'b0;
                    state_nxt     = IDLE;
                end else if (dwell_cnt_r != dwell_last_s) begin
                    dwell_cnt_nxt = dwell_cnt_r + DWELL_W'(1);
                end else begin
                    dwell_cnt_nxt = {DWELL_W{1'b0}};
                    if (state_r == RUN) begin
                        if (step_r == 8'd0) begin
                            // Single-tone mode: hold until aborted.
                            freq_nxt = freq_r;
                        end else if (dist_s <= {1'b0, step_r}) begin
                            // Land exactly on STOP instead of overshooting/wrapping.
                            freq_nxt  = stop_r;
                            state_nxt = LAST;
                        end else if (up_r) begin
                            freq_nxt = freq_r + step_r;
                        end else begin
                            freq_nxt = freq_r - step_r;
                        end
                    end else begin
                        done_nxt = 1'b1;
`ifdef SWEEP_LOOP_EN
                        freq_nxt  = start_r;
                        state_nxt = (start_r == stop_r) ? LAST : RUN;
`else
                        freq_nxt  = 8'd0;
                        state_nxt = IDLE;
`endif
                    end
                end
            end

            default: begin
                freq_nxt      = 8'd0;
                dwell_cnt_nxt = {DWELL_W{1'b0}};
                abort_nxt     = 1'b0;
                state_nxt     = IDLE;
            end
        endcase
    end

endmodule
